// File: rtl/rgb_rx_monitor.sv
// Receive-side monitor for the 18-bit parallel RGB LCD interface: recovers line/frame
// timing and a per-frame rotate-xor pixel checksum, exposed as a 6-word register window.
module rgb_rx_monitor #(
    parameter logic [31:0] BASE_ADDR = 32'hf800_2000,
    parameter int          CNT_W     = 16
) (
    input  logic        clk_50mhz,
    input  logic        rst,
    input  logic        rx_dotclk,
    input  logic        rx_hsync,
    input  logic        rx_vsync,
    input  logic        rx_data_en,
    input  logic [17:0] rx_db,
    input  logic [31:0] bus_addr,
    input  logic        bus_wen,
    input  logic        bus_ren,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        MEAS  = 2'd2
    } state_t;

    localparam logic [31:0] ADDR_CTRL   = BASE_ADDR;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h04;
    localparam logic [31:0] ADDR_HTIM   = BASE_ADDR + 32'h08;
    localparam logic [31:0] ADDR_VTIM   = BASE_ADDR + 32'h0C;
    localparam logic [31:0] ADDR_CHKSUM = BASE_ADDR + 32'h10;
    localparam logic [31:0] ADDR_PIXEL0 = BASE_ADDR + 32'h14;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == CNT_MAX) ? x : x + CNT_ONE;
    endfunction

    // Input capture and pixel-strobe detection
    logic        dotclk_q, dotclk_prev, hsync_q, vsync_q, de_q;
    logic [17:0] db_q;
    logic        hs_prev, vs_prev;
    logic        strobe, line_start, frame_start;

    assign strobe      = dotclk_q & ~dotclk_prev;
    assign line_start  = strobe & hs_prev & ~hsync_q;
    assign frame_start = strobe & vs_prev & ~vsync_q;

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            dotclk_q    <= 1'b0;
            dotclk_prev <= 1'b0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            de_q        <= 1'b0;
            db_q        <= '0;
            hs_prev     <= 1'b0;
            vs_prev     <= 1'b0;
        end else begin
            dotclk_q    <= rx_dotclk;
            dotclk_prev <= dotclk_q;
            hsync_q     <= rx_hsync;
            vsync_q     <= rx_vsync;
            de_q        <= rx_data_en;
            db_q        <= rx_db;
            if (strobe) begin
                hs_prev <= hsync_q;
                vs_prev <= vsync_q;
            end
        end
    end

    // Control / FSM state
    state_t      state;
    logic        ctrl_en, valid, changed;
    logic [15:0] frame_cnt;

    // Running counters for the frame in progress
    logic [CNT_W-1:0] h_cnt, h_act_cnt, v_cnt, va_cnt;
    logic [31:0]      chk;
    logic [17:0]      pix0_cur;
    logic             pix_seen;

    // Published results
    logic [CNT_W-1:0] h_total, h_active, v_total, v_active;
    logic [CNT_W-1:0] snap_ht, snap_ha;
    logic [31:0]      chk_pub;
    logic [17:0]      pix0_pub;

    // Bus: bus_wen is a single-cycle strobe with no backpressure; every access completes
    // in the cycle it is presented, and reads are combinational with no side effects.
    logic wr_ctrl, wr_status;
    assign wr_ctrl   = bus_wen && (bus_addr == ADDR_CTRL);
    assign wr_status = bus_wen && (bus_addr == ADDR_STATUS);

    logic unused_bus;
    assign unused_bus = ^{bus_ren, bus_wdata[31:2]};

    logic             meas, counting, line_has_de, timing_diff;
    logic [CNT_W-1:0] ht_new, ha_new, vt_new, va_new;
    logic [31:0]      chk_base, chk_next;

    // Values after closing the current line; a coincident frame start publishes these.
    always_comb begin
        meas        = (state == MEAS);
        counting    = meas || ((state == ARMED) && frame_start);
        line_has_de = (h_act_cnt != '0);
        ht_new      = h_total;
        ha_new      = h_active;
        vt_new      = v_cnt;
        va_new      = va_cnt;
        if (line_start) begin
            ht_new = h_cnt;
            vt_new = sat_inc(v_cnt);
            if (line_has_de) begin
                ha_new = h_act_cnt;
                va_new = sat_inc(va_cnt);
            end
        end
        timing_diff = (ht_new != snap_ht) || (ha_new != snap_ha) ||
                      (vt_new != v_total) || (va_new != v_active);
        chk_base    = frame_start ? 32'h0 : chk;
        chk_next    = de_q ? ({chk_base[30:0], chk_base[31]} ^ {14'b0, db_q}) : chk_base;
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            state     <= IDLE;
            ctrl_en   <= 1'b0;
            valid     <= 1'b0;
            changed   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (wr_ctrl) ctrl_en <= bus_wdata[0];
            if (wr_status && bus_wdata[1]) changed <= 1'b0;
            if (meas && frame_start) begin
                valid     <= 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
                if (valid && timing_diff) changed <= 1'b1;
            end
            if (!ctrl_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= ARMED;
                        valid     <= 1'b0;
                        frame_cnt <= '0;
                        changed   <= 1'b0;
                    end
                    ARMED:   if (frame_start) state <= MEAS;
                    MEAS:    state <= MEAS;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            h_cnt     <= '0;
            h_act_cnt <= '0;
            v_cnt     <= '0;
            va_cnt    <= '0;
            chk       <= '0;
            pix0_cur  <= '0;
            pix_seen  <= 1'b0;
            h_total   <= '0;
            h_active  <= '0;
            v_total   <= '0;
            v_active  <= '0;
            snap_ht   <= '0;
            snap_ha   <= '0;
            chk_pub   <= '0;
            pix0_pub  <= '0;
        end else if (strobe && counting) begin
            // The strobe that starts a line or frame is the first strobe of the new line.
            if (line_start || frame_start) begin
                h_cnt     <= CNT_ONE;
                h_act_cnt <= de_q ? CNT_ONE : '0;
            end else begin
                h_cnt <= sat_inc(h_cnt);
                if (de_q) h_act_cnt <= sat_inc(h_act_cnt);
            end

            if (frame_start) begin
                v_cnt  <= '0;
                va_cnt <= '0;
            end else begin
                v_cnt  <= vt_new;
                va_cnt <= va_new;
            end

            chk <= chk_next;
            if (frame_start) begin
                pix_seen <= de_q;
                pix0_cur <= de_q ? db_q : 18'h0;
            end else if (de_q && !pix_seen) begin
                pix_seen <= 1'b1;
                pix0_cur <= db_q;
            end

            if (meas && line_start) begin
                h_total  <= ht_new;
                h_active <= ha_new;
            end

            if (meas && frame_start) begin
                v_total  <= vt_new;
                v_active <= va_new;
                chk_pub  <= chk;
                pix0_pub <= pix0_cur;
                snap_ht  <= ht_new;
                snap_ha  <= ha_new;
            end
        end
    end

    always_comb begin
        bus_rdata = 32'h0;
        case (bus_addr)
            ADDR_CTRL:   bus_rdata = {31'b0, ctrl_en};
            ADDR_STATUS: bus_rdata = {frame_cnt, 12'b0, state, changed, valid};
            ADDR_HTIM:   bus_rdata = {16'(h_active), 16'(h_total)};
            ADDR_VTIM:   bus_rdata = {16'(v_active), 16'(v_total)};
            ADDR_CHKSUM: bus_rdata = chk_pub;
            ADDR_PIXEL0: bus_rdata = {14'b0, pix0_pub};
            default:     bus_rdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_rgb_rx_monitor.sv
// Directed bench for rgb_rx_monitor using a scaled-down raster (12 strobes/line, 8 lines,
// 6x4 active) and 8-bit timing counters so saturation is reachable quickly.
module tb_rgb_rx_monitor;

    localparam logic [31:0] BASE = 32'hf800_2000;
    localparam int H_NOM   = 12;
    localparam int HS_W    = 2;
    localparam int HA_BEG  = 3;
    localparam int HA_N    = 6;
    localparam int V_NOM   = 8;
    localparam int VS_W    = 2;
    localparam int VA_BEG  = 2;
    localparam int VA_N    = 4;

    logic        clk_50mhz = 1'b0;
    logic        rst;
    logic        rx_dotclk, rx_hsync, rx_vsync, rx_data_en;
    logic [17:0] rx_db;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_wen, bus_ren;

    int n_checks = 0;
    int n_errors = 0;

    rgb_rx_monitor #(.BASE_ADDR(BASE), .CNT_W(8)) dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .rx_dotclk (rx_dotclk),
        .rx_hsync  (rx_hsync),
        .rx_vsync  (rx_vsync),
        .rx_data_en(rx_data_en),
        .rx_db     (rx_db),
        .bus_addr  (bus_addr),
        .bus_wen   (bus_wen),
        .bus_ren   (bus_ren),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata)
    );

    // Clock / reset
    always #10 clk_50mhz = ~clk_50mhz;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic bus_write(input logic [31:0] off, input logic [31:0] data);
        @(negedge clk_50mhz);
        bus_addr  = BASE + off;
        bus_wdata = data;
        bus_wen   = 1'b1;
        @(negedge clk_50mhz);
        bus_wen   = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] got;
        @(negedge clk_50mhz);
        bus_addr = BASE + off;
        bus_ren  = 1'b1;
        #1 got = bus_rdata;
        bus_ren  = 1'b0;
        check_eq(tag, got, exp);
    endtask

    task automatic pixel(input logic hs, input logic vs, input logic de, input logic [17:0] db);
        @(negedge clk_50mhz);
        rx_dotclk  = 1'b0;
        rx_hsync   = hs;
        rx_vsync   = vs;
        rx_data_en = de;
        rx_db      = db;
        @(negedge clk_50mhz);
        @(negedge clk_50mhz);
        rx_dotclk  = 1'b1;
        @(negedge clk_50mhz);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pixel(1'b1, 1'b1, 1'b0, 18'h0);
    endtask

    // One frame; returns the reference checksum and first active pixel it carries.
    task automatic send_frame(input int htot, input int nlines, input bit ramp,
                              input logic [17:0] base,
                              output logic [31:0] chk, output logic [17:0] pix0);
        logic [17:0] val;
        logic        de;
        int          k;
        chk  = 32'h0;
        pix0 = 18'h0;
        k    = 0;
        for (int v = 0; v < nlines; v++) begin
            for (int h = 0; h < htot; h++) begin
                de  = (v >= VA_BEG) && (v < VA_BEG + VA_N) && (h >= HA_BEG) && (h < HA_BEG + HA_N);
                val = ramp ? (base + 18'(k)) : 18'h3FFFF;
                if (de) begin
                    if (k == 0) pix0 = val;
                    chk = {chk[30:0], chk[31]} ^ {14'b0, val};
                    k++;
                end
                pixel(h >= HS_W, v >= VS_W, de, de ? val : 18'h2AAAA);
            end
        end
    endtask

    logic [31:0] chk_const, chk_ramp, chk_tmp;
    logic [17:0] pix_const, pix_ramp, pix_tmp;

    initial begin
        rst = 1'b1;
        rx_dotclk = 1'b0; rx_hsync = 1'b1; rx_vsync = 1'b1; rx_data_en = 1'b0; rx_db = 18'h0;
        bus_addr = BASE; bus_wdata = 32'h0; bus_wen = 1'b0; bus_ren = 1'b0;
        repeat (4) @(negedge clk_50mhz);
        rst = 1'b0;

        read_check("rst_ctrl",   32'h00, 32'h0);
        read_check("rst_status", 32'h04, 32'h0);
        read_check("rst_htim",   32'h08, 32'h0);
        read_check("rst_vtim",   32'h0C, 32'h0);
        read_check("rst_chk",    32'h10, 32'h0);
        read_check("rst_pix0",   32'h14, 32'h0);
        idle(4);

        // Nominal timing, constant pixels, three frames
        bus_write(32'h00, 32'h1);
        read_check("armed_status", 32'h04, 32'h0000_0004);
        send_frame(H_NOM, V_NOM, 1'b0, 18'h0, chk_const, pix_const);
        send_frame(H_NOM, V_NOM, 1'b0, 18'h0, chk_tmp, pix_tmp);
        send_frame(H_NOM, V_NOM, 1'b0, 18'h0, chk_tmp, pix_tmp);
        read_check("nom_status", 32'h04, 32'h0002_0009);
        read_check("nom_htim",   32'h08, 32'h0006_000C);
        read_check("nom_vtim",   32'h0C, 32'h0004_0008);
        read_check("const_chk",  32'h10, chk_const);
        read_check("const_pix0", 32'h14, 32'h0003_FFFF);

        // Ramp frame, published at the start of the following frame
        send_frame(H_NOM, V_NOM, 1'b1, 18'h01234, chk_ramp, pix_ramp);
        send_frame(H_NOM, V_NOM, 1'b0, 18'h0, chk_tmp, pix_tmp);
        read_check("ramp_chk",    32'h10, chk_ramp);
        read_check("ramp_pix0",   32'h14, {14'b0, pix_ramp});
        read_check("ramp_status", 32'h04, 32'h0004_0009);

        // One frame with one extra front-porch strobe per line
        send_frame(H_NOM + 1, V_NOM, 1'b0, 18'h0, chk_tmp, pix_tmp);
        read_check("hfp_htim", 32'h08, 32'h0006_000D);
        send_frame(H_NOM, V_NOM, 1'b0, 18'h0, chk_tmp, pix_tmp);
        read_check("hfp_changed", 32'h04, 32'h0006_000B);
        bus_write(32'h04, 32'h2);
        read_check("changed_clr", 32'h04, 32'h0006_0009);
        send_frame(H_NOM, V_NOM, 1'b0, 18'h0, chk_tmp, pix_tmp);
        read_check("changed_again", 32'h04, 32'h0007_000B);

        // hsync held high long enough to saturate the 8-bit line counter
        idle(300);
        pixel(1'b0, 1'b1, 1'b0, 18'h0);
        read_check("sat_htim", 32'h08, 32'h0006_00FF);
        idle(2);

        // Disable then re-enable
        bus_write(32'h00, 32'h0);
        read_check("dis_status", 32'h04, 32'h0007_0003);
        read_check("dis_htim",   32'h08, 32'h0006_00FF);
        bus_write(32'h00, 32'h1);
        read_check("reen_status", 32'h04, 32'h0000_0004);
        send_frame(H_NOM, V_NOM, 1'b0, 18'h0, chk_tmp, pix_tmp);
        read_check("reen_first", 32'h04, 32'h0000_0008);
        send_frame(H_NOM, V_NOM, 1'b0, 18'h0, chk_tmp, pix_tmp);
        read_check("reen_publish", 32'h04, 32'h0001_0009);
        read_check("reen_vtim",    32'h0C, 32'h0004_0008);
        read_check("reen_chk",     32'h10, chk_const);

        // Reset in the middle of a frame
        send_frame(H_NOM, 4, 1'b0, 18'h0, chk_tmp, pix_tmp);
        @(negedge clk_50mhz);
        rst = 1'b1;
        repeat (3) @(negedge clk_50mhz);
        rst = 1'b0;
        read_check("mid_rst_ctrl",   32'h00, 32'h0);
        read_check("mid_rst_status", 32'h04, 32'h0);
        read_check("mid_rst_htim",   32'h08, 32'h0);
        read_check("mid_rst_vtim",   32'h0C, 32'h0);
        read_check("mid_rst_chk",    32'h10, 32'h0);
        read_check("mid_rst_pix0",   32'h14, 32'h0);
        read_check("unmapped",       32'h18, 32'h0);
        bus_write(32'h08, 32'h1234_5678);
        read_check("ro_htim", 32'h08, 32'h0);
        bus_write(32'h00, 32'h1);
        read_check("ctrl_rw",      32'h00, 32'h1);
        read_check("ctrl_arm_sts", 32'h04, 32'h0000_0004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
